// File: rtl/decode_field_sequencer_if.sv
// Byte-in / record-out bundle of the ADC-family field sequencer.
// master drives bytes and takes records; slave is the sequencer.
interface decode_field_sequencer_if;
  logic        i_flush;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [7:0]  o_opcode;
  logic        o_w_is_present;
  logic        o_w;
  logic        o_s_is_present;
  logic        o_s;
  logic        o_mod_rm_is_present;
  logic [1:0]  o_mod;
  logic [2:0]  o_reg;
  logic [2:0]  o_rm;
  logic        o_sib_is_present;
  logic [7:0]  o_sib;
  logic [31:0] o_disp;
  logic [2:0]  o_disp_size;
  logic [31:0] o_imm;
  logic [2:0]  o_imm_size;
  logic        o_opsize_ovr;
  logic        o_addrsize_ovr;
  logic [3:0]  o_length;
  logic        o_error;

  modport master (
    output i_flush, i_byte_valid, i_byte, i_inst_ready,
    input  o_byte_ready, o_inst_valid, o_opcode,
    input  o_w_is_present, o_w, o_s_is_present, o_s,
    input  o_mod_rm_is_present, o_mod, o_reg, o_rm,
    input  o_sib_is_present, o_sib,
    input  o_disp, o_disp_size, o_imm, o_imm_size,
    input  o_opsize_ovr, o_addrsize_ovr, o_length, o_error
  );

  modport slave (
    input  i_flush, i_byte_valid, i_byte, i_inst_ready,
    output o_byte_ready, o_inst_valid, o_opcode,
    output o_w_is_present, o_w, o_s_is_present, o_s,
    output o_mod_rm_is_present, o_mod, o_reg, o_rm,
    output o_sib_is_present, o_sib,
    output o_disp, o_disp_size, o_imm, o_imm_size,
    output o_opsize_ovr, o_addrsize_ovr, o_length, o_error
  );
endinterface

// File: rtl/decode_field_sequencer.sv
// Byte-serial ADC-family field sequencer: one byte per cycle,
// one assembled field record per instruction.
module decode_field_sequencer #(
  parameter int MAX_LEN    = 15,
  parameter bit DEFAULT_32 = 1'b1
) (
  input logic i_clk,
  input logic i_rst_n,
  decode_field_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_PREFIX, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE
  } state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        w_pres;
    logic        w;
    logic        s_pres;
    logic        s;
    logic        modrm_pres;
    logic [1:0]  mod;
    logic [2:0]  rg;
    logic [2:0]  rm;
    logic        sib_pres;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic [2:0]  disp_size;
    logic [31:0] imm;
    logic [2:0]  imm_size;
    logic        opsz;
    logic        adsz;
    logic [3:0]  len;
    logic        err;
  } rec_t;

  state_e     state_q;
  rec_t       rec_q;
  logic [1:0] cnt_q;
  logic       valid_q;
  logic       rdy_q;

  state_e     nxt;
  logic       bad;
  logic       opc_ok;
  logic       go_after;
  logic       disp_end;
  logic [2:0] dsz;
  logic [2:0] isz;
  logic [3:0] len_n;
  logic [2:0] cnt_n;
  logic       acc;
  logic       a32;
  logic       o32;
  logic       grp;
  logic [7:0] b;

  function automatic logic [2:0] imm_sz(
    input logic [7:0] op,
    input logic       big
  );
    if (!op[0] || op == 8'h83) return 3'd1;
    else if (big)              return 3'd4;
    else                       return 3'd2;
  endfunction

  // Shared by mod_r/m and SIB: for SIB, rm carries the base field.
  function automatic logic [2:0] disp_sz(
    input logic [1:0] md,
    input logic [2:0] r,
    input logic       wide
  );
    unique case (md)
      2'b01:   return 3'd1;
      2'b10:   return wide ? 3'd4 : 3'd2;
      2'b00: begin
        if (wide && r == 3'b101)       return 3'd4;
        else if (!wide && r == 3'b110) return 3'd2;
        else                           return 3'd0;
      end
      default: return 3'd0;
    endcase
  endfunction

  assign b   = bus.i_byte;
  assign acc = bus.i_byte_valid & rdy_q & ~bus.i_flush;
  assign a32 = DEFAULT_32 ^ rec_q.adsz;
  assign o32 = DEFAULT_32 ^ rec_q.opsz;
  assign grp = rec_q.opcode[7];

  always_comb begin
    nxt      = state_q;
    bad      = 1'b0;
    opc_ok   = 1'b0;
    go_after = 1'b0;
    disp_end = 1'b0;
    dsz      = 3'd0;
    isz      = 3'd0;
    len_n    = rec_q.len + 4'd1;
    cnt_n    = {1'b0, cnt_q} + 3'd1;
    unique case (state_q)
      S_PREFIX: begin
        unique case (1'b1)
          (b == 8'h66 || b == 8'h67): nxt = S_PREFIX;
          (b[7:2] == 6'b000100): begin
            opc_ok = 1'b1;
            nxt    = S_MODRM;
          end
          (b == 8'h14 || b == 8'h15): begin
            opc_ok = 1'b1;
            nxt    = S_IMM;
            isz    = imm_sz(b, o32);
          end
          (b == 8'h80 || b == 8'h81 || b == 8'h83): begin
            opc_ok = 1'b1;
            nxt    = S_MODRM;
          end
          default: begin
            nxt = S_DONE;
            bad = 1'b1;
          end
        endcase
      end
      S_MODRM: begin
        if (grp && b[5:3] != 3'b010) begin
          nxt = S_DONE;
          bad = 1'b1;
        end else if (a32 && b[7:6] != 2'b11 && b[2:0] == 3'b100) begin
          nxt = S_SIB;
        end else begin
          dsz      = disp_sz(b[7:6], b[2:0], a32);
          go_after = 1'b1;
        end
      end
      S_SIB: begin
        dsz      = disp_sz(rec_q.mod, b[2:0], 1'b1);
        go_after = 1'b1;
      end
      S_DISP: disp_end = (cnt_n == rec_q.disp_size);
      S_IMM: begin
        if (cnt_n == rec_q.imm_size) nxt = S_DONE;
      end
      default: nxt = state_q;
    endcase
    if (go_after && dsz != 3'd0) begin
      nxt = S_DISP;
    end else if (go_after || disp_end) begin
      if (grp) begin
        nxt = S_IMM;
        isz = imm_sz(rec_q.opcode, o32);
      end else begin
        nxt = S_DONE;
      end
    end
    // Running out of length budget mid-instruction ends it as an error.
    if (state_q != S_DONE && nxt != S_DONE && len_n == 4'(MAX_LEN)) begin
      nxt = S_DONE;
      bad = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_PREFIX;
      rec_q   <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (bus.i_flush) begin
      state_q <= S_PREFIX;
      rec_q   <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (state_q == S_DONE) begin
      if (valid_q && bus.i_inst_ready) begin
        state_q <= S_PREFIX;
        rec_q   <= '0;
        cnt_q   <= 2'd0;
        valid_q <= 1'b0;
        rdy_q   <= 1'b1;
      end
    end else if (acc) begin
      state_q   <= nxt;
      rec_q.len <= len_n;
      rec_q.err <= bad;
      cnt_q     <= (nxt == state_q) ? cnt_n[1:0] : 2'd0;
      if (nxt == S_DONE) begin
        valid_q <= 1'b1;
        rdy_q   <= 1'b0;
      end
      if (dsz != 3'd0) rec_q.disp_size <= dsz;
      if (isz != 3'd0) rec_q.imm_size  <= isz;
      unique case (state_q)
        S_PREFIX: begin
          if (b == 8'h66) rec_q.opsz <= 1'b1;
          if (b == 8'h67) rec_q.adsz <= 1'b1;
          if (opc_ok) begin
            rec_q.opcode <= b;
            rec_q.w_pres <= 1'b1;
            rec_q.w      <= b[0];
            rec_q.s_pres <= b[7];
            rec_q.s      <= b[7] & b[1];
          end
        end
        S_MODRM: begin
          rec_q.modrm_pres <= 1'b1;
          rec_q.mod        <= b[7:6];
          rec_q.rg         <= b[5:3];
          rec_q.rm         <= b[2:0];
        end
        S_SIB: begin
          rec_q.sib_pres <= 1'b1;
          rec_q.sib      <= b;
        end
        S_DISP:  rec_q.disp[{cnt_q, 3'b000} +: 8] <= b;
        S_IMM:   rec_q.imm[{cnt_q, 3'b000} +: 8]  <= b;
        default: rec_q.err <= bad;
      endcase
    end
  end

  assign bus.o_byte_ready        = rdy_q;
  assign bus.o_inst_valid        = valid_q;
  assign bus.o_opcode            = rec_q.opcode;
  assign bus.o_w_is_present      = rec_q.w_pres;
  assign bus.o_w                 = rec_q.w;
  assign bus.o_s_is_present      = rec_q.s_pres;
  assign bus.o_s                 = rec_q.s;
  assign bus.o_mod_rm_is_present = rec_q.modrm_pres;
  assign bus.o_mod               = rec_q.mod;
  assign bus.o_reg               = rec_q.rg;
  assign bus.o_rm                = rec_q.rm;
  assign bus.o_sib_is_present    = rec_q.sib_pres;
  assign bus.o_sib               = rec_q.sib;
  assign bus.o_disp              = rec_q.disp;
  assign bus.o_disp_size         = rec_q.disp_size;
  assign bus.o_imm               = rec_q.imm;
  assign bus.o_imm_size          = rec_q.imm_size;
  assign bus.o_opsize_ovr        = rec_q.opsz;
  assign bus.o_addrsize_ovr      = rec_q.adsz;
  assign bus.o_length            = rec_q.len;
  assign bus.o_error             = rec_q.err;

endmodule

// File: tb/tb_decode_field_sequencer.sv
// Directed-vector bench for decode_field_sequencer.
// Hand-computed expectations for each ADC-family sequence.
module tb_decode_field_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  decode_field_sequencer_if bus ();

  decode_field_sequencer #(
    .MAX_LEN    (15),
    .DEFAULT_32 (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = v;
    while (!bus.o_byte_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("send_to", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic take();
    int n;
    n = 0;
    bus.i_inst_ready = 1'b1;
    while (!bus.o_inst_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("take_to", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.i_inst_ready = 1'b0;
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    bus.i_inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rdy", 32'(bus.o_byte_ready), 32'd1);
    chk("rst_val", 32'(bus.o_inst_valid), 32'd0);
    chk("rst_len", 32'(bus.o_length), 32'd0);
    chk("rst_err", 32'(bus.o_error), 32'd0);
    chk("rst_op", 32'(bus.o_opcode), 32'd0);

    // 11 D8: register form, no disp/imm
    send(8'h11); send(8'hD8);
    chk("t1_val", 32'(bus.o_inst_valid), 32'd1);
    chk("t1_op", 32'(bus.o_opcode), 32'h11);
    chk("t1_w", 32'(bus.o_w), 32'd1);
    chk("t1_wp", 32'(bus.o_w_is_present), 32'd1);
    chk("t1_sp", 32'(bus.o_s_is_present), 32'd0);
    chk("t1_mod", 32'(bus.o_mod), 32'd3);
    chk("t1_reg", 32'(bus.o_reg), 32'd3);
    chk("t1_rm", 32'(bus.o_rm), 32'd0);
    chk("t1_dsz", 32'(bus.o_disp_size), 32'd0);
    chk("t1_isz", 32'(bus.o_imm_size), 32'd0);
    chk("t1_len", 32'(bus.o_length), 32'd2);
    chk("t1_err", 32'(bus.o_error), 32'd0);
    chk("t1_rdy", 32'(bus.o_byte_ready), 32'd0);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'h81;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_op", 32'(bus.o_opcode), 32'h11);
      chk("hold_len", 32'(bus.o_length), 32'd2);
      chk("hold_val", 32'(bus.o_inst_valid), 32'd1);
      chk("hold_rdy", 32'(bus.o_byte_ready), 32'd0);
    end
    bus.i_byte_valid = 1'b0;
    take();
    chk("bub_rdy", 32'(bus.o_byte_ready), 32'd1);
    chk("bub_val", 32'(bus.o_inst_valid), 32'd0);
    chk("bub_len", 32'(bus.o_length), 32'd0);

    // 66 15 34 12: 16-bit immediate under operand-size override
    send(8'h66); send(8'h15); send(8'h34); send(8'h12);
    chk("t2_val", 32'(bus.o_inst_valid), 32'd1);
    chk("t2_ovr", 32'(bus.o_opsize_ovr), 32'd1);
    chk("t2_imm", bus.o_imm, 32'h0000_1234);
    chk("t2_isz", 32'(bus.o_imm_size), 32'd2);
    chk("t2_sp", 32'(bus.o_s_is_present), 32'd0);
    chk("t2_len", 32'(bus.o_length), 32'd4);
    take();

    // 81 54 24 08 78 56 34 12: SIB, disp8, imm32
    send(8'h81); send(8'h54); send(8'h24); send(8'h08);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("t3_reg", 32'(bus.o_reg), 32'd2);
    chk("t3_rm", 32'(bus.o_rm), 32'd4);
    chk("t3_sibp", 32'(bus.o_sib_is_present), 32'd1);
    chk("t3_sib", 32'(bus.o_sib), 32'h24);
    chk("t3_disp", bus.o_disp, 32'h0000_0008);
    chk("t3_dsz", 32'(bus.o_disp_size), 32'd1);
    chk("t3_imm", bus.o_imm, 32'h1234_5678);
    chk("t3_isz", 32'(bus.o_imm_size), 32'd4);
    chk("t3_len", 32'(bus.o_length), 32'd8);
    chk("t3_err", 32'(bus.o_error), 32'd0);
    take();

    // 83 D0 FF: sign-extended imm8
    send(8'h83); send(8'hD0); send(8'hFF);
    chk("t4_s", 32'(bus.o_s), 32'd1);
    chk("t4_sp", 32'(bus.o_s_is_present), 32'd1);
    chk("t4_w", 32'(bus.o_w), 32'd1);
    chk("t4_imm", bus.o_imm, 32'h0000_00FF);
    chk("t4_isz", 32'(bus.o_imm_size), 32'd1);
    chk("t4_len", 32'(bus.o_length), 32'd3);
    take();
    send(8'h80); send(8'hD8);
    chk("t4e_val", 32'(bus.o_inst_valid), 32'd1);
    chk("t4e_err", 32'(bus.o_error), 32'd1);
    chk("t4e_reg", 32'(bus.o_reg), 32'd3);
    chk("t4e_len", 32'(bus.o_length), 32'd2);
    take();

    // 0F unsupported; then fifteen 66 hitting the length limit
    send(8'h0F);
    chk("t5_err", 32'(bus.o_error), 32'd1);
    chk("t5_len", 32'(bus.o_length), 32'd1);
    take();
    for (int i = 0; i < 14; i++) send(8'h66);
    chk("t5_pre", 32'(bus.o_inst_valid), 32'd0);
    send(8'h66);
    chk("t5m_val", 32'(bus.o_inst_valid), 32'd1);
    chk("t5m_err", 32'(bus.o_error), 32'd1);
    chk("t5m_len", 32'(bus.o_length), 32'd15);
    chk("t5m_ovr", 32'(bus.o_opsize_ovr), 32'd1);
    take();

    // 81 54 then flush (byte 14 offered but dropped), then 14 05
    send(8'h81); send(8'h54);
    bus.i_flush      = 1'b1;
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'h14;
    @(posedge clk); #1;
    bus.i_flush      = 1'b0;
    bus.i_byte_valid = 1'b0;
    chk("fl_len", 32'(bus.o_length), 32'd0);
    chk("fl_val", 32'(bus.o_inst_valid), 32'd0);
    chk("fl_op", 32'(bus.o_opcode), 32'd0);
    send(8'h14); send(8'h05);
    chk("t6_op", 32'(bus.o_opcode), 32'h14);
    chk("t6_imm", bus.o_imm, 32'h0000_0005);
    chk("t6_isz", 32'(bus.o_imm_size), 32'd1);
    chk("t6_len", 32'(bus.o_length), 32'd2);
    chk("t6_mrp", 32'(bus.o_mod_rm_is_present), 32'd0);
    take();

    // asynchronous reset mid-instruction
    send(8'h11);
    chk("ar_pre", 32'(bus.o_length), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_len", 32'(bus.o_length), 32'd0);
    chk("ar_rdy", 32'(bus.o_byte_ready), 32'd1);
    chk("ar_op", 32'(bus.o_opcode), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
